// File: rtl/debug_ring_station.sv
// One station on a CHANNELS-wide unidirectional debug ring: per-channel input FIFOs,
// ejection of packets addressed to `id`, and packet-atomic local injection on channel 0.
// Flit layout on every flit port: [17] valid, [16] last, [15:0] data.
module debug_ring_station #(
    parameter int CHANNELS    = 2,
    parameter int BUFFER_SIZE = 4,
    parameter int ID_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              id,
    input  logic [CHANNELS*18-1:0]   ring_in,
    output logic [CHANNELS-1:0]      ring_in_ready,
    output logic [CHANNELS*18-1:0]   ring_out,
    input  logic [CHANNELS-1:0]      ring_out_ready,
    input  logic [17:0]              local_in,
    output logic                     local_in_ready,
    output logic [17:0]              local_out,
    input  logic                     local_out_ready
);
    localparam int FW = 18;
    localparam int PW = $clog2(BUFFER_SIZE);
    localparam int CW = $clog2(BUFFER_SIZE + 1);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {R_HEAD, R_EJECT, R_FWD} route_t;
    typedef enum logic [1:0] {A_IDLE, A_RING, A_LOCAL} arb_t;

    logic [16:0]         mem [CHANNELS][BUFFER_SIZE];
    logic [PW-1:0]       wptr [CHANNELS];
    logic [PW-1:0]       rptr [CHANNELS];
    logic [CW-1:0]       count [CHANNELS];
    logic [CW-1:0]       count_n [CHANNELS];
    route_t              route [CHANNELS];
    route_t              route_n [CHANNELS];
    logic [16:0]         head [CHANNELS];
    logic [CHANNELS-1:0] head_valid, to_local, fwd_req, ej_req, rd, wr;

    logic          ej_busy, ej_busy_n, ej_any, ej_xfer, ej_found;
    logic [SW-1:0] ej_sel, ej_sel_n, ej_ptr, ej_ptr_n, ej_gnt;
    int unsigned   idx;

    arb_t arb, arb_n;
    logic prio_local, prio_local_n, running, sel_local, ring_req, loc_req, out0_valid, xfer0;

    always_comb begin
        ring_out       = '0;
        local_out      = '0;
        local_in_ready = 1'b0;
        head_valid     = '0;
        to_local       = '0;
        fwd_req        = '0;
        ej_req         = '0;
        rd             = '0;
        wr             = '0;
        idx            = 0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            head[c]       = mem[c][rptr[c]];
            head_valid[c] = (count[c] != '0);
            // In HEAD the decision is made on the very flit being routed.
            to_local[c]   = (route[c] == R_HEAD) ? (head[c][ID_WIDTH-1:0] == id[ID_WIDTH-1:0])
                                                 : (route[c] == R_EJECT);
            fwd_req[c]    = head_valid[c] && !to_local[c];
            ej_req[c]     = head_valid[c] && to_local[c];
            wr[c]         = ring_in[c*FW+17] && ring_in_ready[c];
        end

        ej_gnt   = ej_sel;
        ej_found = 1'b0;
        if (ej_busy) begin
            ej_found = ej_req[ej_sel];
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                idx = (int'(ej_ptr) + i) % CHANNELS;
                if (!ej_found && ej_req[idx]) begin
                    ej_found = 1'b1;
                    ej_gnt   = SW'(idx);
                end
            end
        end
        ej_any    = ej_found;
        ej_xfer   = ej_any && local_out_ready;
        ej_busy_n = ej_busy;
        ej_sel_n  = ej_sel;
        ej_ptr_n  = ej_ptr;
        if (ej_any) local_out = {1'b1, head[ej_gnt]};
        if (ej_xfer) begin
            ej_busy_n = !head[ej_gnt][16];
            ej_sel_n  = ej_gnt;
            if (!ej_busy) ej_ptr_n = (int'(ej_gnt) == CHANNELS - 1) ? '0 : ej_gnt + 1'b1;
        end

        ring_req = fwd_req[0];
        loc_req  = local_in[17] && running;
        case (arb)
            A_RING:  sel_local = 1'b0;
            A_LOCAL: sel_local = 1'b1;
            default: sel_local = (ring_req && loc_req) ? prio_local : loc_req;
        endcase
        out0_valid     = sel_local ? loc_req : ring_req;
        xfer0          = out0_valid && ring_out_ready[0];
        local_in_ready = sel_local && ring_out_ready[0] && running;
        if (out0_valid) ring_out[FW-1:0] = {1'b1, sel_local ? local_in[16:0] : head[0]};
        arb_n        = arb;
        prio_local_n = prio_local;
        if (xfer0) begin
            if (sel_local ? local_in[16] : head[0][16]) begin
                arb_n        = A_IDLE;
                prio_local_n = !sel_local;
            end else begin
                arb_n = sel_local ? A_LOCAL : A_RING;
            end
        end

        for (int unsigned c = 0; c < CHANNELS; c++) begin
            rd[c] = ej_xfer && (ej_gnt == SW'(c));
            if (c == 0) rd[c] = rd[c] || (xfer0 && !sel_local);
            else        rd[c] = rd[c] || (fwd_req[c] && ring_out_ready[c]);
            if (c != 0 && fwd_req[c]) ring_out[c*FW +: FW] = {1'b1, head[c]};
            count_n[c] = count[c] + CW'(wr[c]) - CW'(rd[c]);
            route_n[c] = route[c];
            if (rd[c]) begin
                if (head[c][16])               route_n[c] = R_HEAD;
                else if (route[c] == R_HEAD)   route_n[c] = to_local[c] ? R_EJECT : R_FWD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                wptr[c]  <= '0;
                rptr[c]  <= '0;
                count[c] <= '0;
                route[c] <= R_HEAD;
            end
            ring_in_ready <= '0;
            ej_busy       <= 1'b0;
            ej_sel        <= '0;
            ej_ptr        <= '0;
            arb           <= A_IDLE;
            prio_local    <= 1'b0;
            running       <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (wr[c]) wptr[c] <= (wptr[c] == PW'(BUFFER_SIZE - 1)) ? '0 : wptr[c] + 1'b1;
                if (rd[c]) rptr[c] <= (rptr[c] == PW'(BUFFER_SIZE - 1)) ? '0 : rptr[c] + 1'b1;
                count[c]         <= count_n[c];
                route[c]         <= route_n[c];
                ring_in_ready[c] <= (count_n[c] < CW'(BUFFER_SIZE));
            end
            ej_busy    <= ej_busy_n;
            ej_sel     <= ej_sel_n;
            ej_ptr     <= ej_ptr_n;
            arb        <= arb_n;
            prio_local <= prio_local_n;
            running    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (wr[c]) mem[c][wptr[c]] <= ring_in[c*FW +: 17];
        end
    end
endmodule

// File: tb/tb_debug_ring_station.sv
// Directed bench for debug_ring_station (2 channels, id 0x0005): queue-driven sources,
// negedge monitors, and hand-computed expected flit sequences {last, data}.
module tb_debug_ring_station;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] id = 16'h0005;
    logic [35:0] ring_in;
    logic [1:0]  ring_in_ready;
    logic [35:0] ring_out;
    logic [1:0]  ring_out_ready;
    logic [17:0] local_in;
    logic        local_in_ready;
    logic [17:0] local_out;
    logic        local_out_ready;

    debug_ring_station #(.CHANNELS(2), .BUFFER_SIZE(4), .ID_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .id(id),
        .ring_in(ring_in), .ring_in_ready(ring_in_ready),
        .ring_out(ring_out), .ring_out_ready(ring_out_ready),
        .local_in(local_in), .local_in_ready(local_in_ready),
        .local_out(local_out), .local_out_ready(local_out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt0 = 0;
    logic [2:0] acc = '0;
    logic [16:0] src0[$], src1[$], srcl[$];
    logic [16:0] out0[$], out1[$], outl[$], exp_q[$];
    int in1_cyc[$], out1_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int sel, input int base);
        int n;
        logic [16:0] v;
        n = (sel == 0) ? out0.size() : (sel == 1) ? out1.size() : outl.size();
        check({tag, "_count"}, 32'(n - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            v = '1;
            if (base + i < n) v = (sel == 0) ? out0[base+i] : (sel == 1) ? out1[base+i] : outl[base+i];
            check($sformatf("%s_flit%0d", tag, i), 32'(v), 32'(exp_q[i]));
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (acc[0] && src0.size() > 0) void'(src0.pop_front());
        if (acc[1] && src1.size() > 0) void'(src1.pop_front());
        if (acc[2] && srcl.size() > 0) void'(srcl.pop_front());
        ring_in[17:0]  = (src0.size() > 0) ? {1'b1, src0[0]} : '0;
        ring_in[35:18] = (src1.size() > 0) ? {1'b1, src1[0]} : '0;
        local_in       = (srcl.size() > 0) ? {1'b1, srcl[0]} : '0;
    end

    always @(negedge clk) begin
        acc[0] = ring_in[17] && ring_in_ready[0];
        acc[1] = ring_in[35] && ring_in_ready[1];
        acc[2] = local_in[17] && local_in_ready;
        if (acc[0]) acc_cnt0++;
        if (acc[1]) in1_cyc.push_back(cyc);
        if (ring_out[17] && ring_out_ready[0]) out0.push_back(ring_out[16:0]);
        if (ring_out[35] && ring_out_ready[1]) begin
            out1.push_back(ring_out[34:18]);
            out1_cyc.push_back(cyc);
        end
        if (local_out[17] && local_out_ready) outl.push_back(local_out[16:0]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, bl, bi1, a0;
        ring_out_ready  = 2'b11;
        local_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", 32'(ring_in_ready), 32'h0);
        check("rst_out_valid", 32'({ring_out[35], ring_out[17]}), 32'h0);
        check("rst_local_out", 32'(local_out), 32'h0);
        check("rst_local_in_ready", 32'(local_in_ready), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("ready_registered", 32'(ring_in_ready), 32'h0);
        @(posedge clk) #2 check("ready_after_rst", 32'(ring_in_ready), 32'h3);

        // Forward on channel 1
        b1 = out1.size(); bl = outl.size(); bi1 = in1_cyc.size();
        @(negedge clk);
        src1.push_back(17'h00007); src1.push_back(17'h0AAAA); src1.push_back(17'h1BBBB);
        repeat (8) @(posedge clk);
        exp_q = '{17'h00007, 17'h0AAAA, 17'h1BBBB};
        check_out("fwd", 1, b1);
        check("fwd_latency", (out1_cyc.size() > b1 && in1_cyc.size() > bi1) ?
              32'(out1_cyc[b1] - in1_cyc[bi1]) : 32'hFFFF_FFFF, 32'd1);
        check("fwd_b2b", (out1_cyc.size() > b1 + 2) ? 32'(out1_cyc[b1+2] - out1_cyc[b1]) : 32'hFFFF_FFFF, 32'd2);
        check("fwd_no_eject", 32'(outl.size() - bl), 32'h0);

        // Eject contention
        b0 = out0.size(); b1 = out1.size(); bl = outl.size();
        @(negedge clk);
        src0.push_back(17'h00005); src0.push_back(17'h11111);
        src1.push_back(17'h00005); src1.push_back(17'h12222);
        repeat (10) @(posedge clk);
        exp_q = '{17'h00005, 17'h11111, 17'h00005, 17'h12222};
        check_out("eject", 2, bl);
        check("eject_no_fwd", 32'((out0.size() - b0) + (out1.size() - b1)), 32'h0);

        // Injection fairness on channel 0
        b0 = out0.size(); bl = outl.size();
        @(negedge clk);
        src0.push_back(17'h00009); src0.push_back(17'h1A001);
        src0.push_back(17'h00009); src0.push_back(17'h1A002);
        src0.push_back(17'h00009); src0.push_back(17'h1A003);
        @(negedge clk);
        srcl.push_back(17'h00005); srcl.push_back(17'h11001);
        srcl.push_back(17'h00005); srcl.push_back(17'h11002);
        repeat (20) @(posedge clk);
        exp_q = '{17'h00009, 17'h1A001, 17'h00005, 17'h11001, 17'h00009, 17'h1A002,
                  17'h00005, 17'h11002, 17'h00009, 17'h1A003};
        check_out("inject", 0, b0);
        check("inject_no_loopback", 32'(outl.size() - bl), 32'h0);

        // Backpressure on a full channel-0 FIFO
        @(negedge clk) ring_out_ready = 2'b10;
        b0 = out0.size(); a0 = acc_cnt0;
        for (int i = 1; i <= 6; i++) src0.push_back(17'h10110 + 17'(i));
        repeat (10) @(posedge clk);
        #2;
        check("bp_accepted", 32'(acc_cnt0 - a0), 32'd4);
        check("bp_ready_low", 32'(ring_in_ready[0]), 32'h0);
        check("bp_held", 32'(out0.size() - b0), 32'h0);
        @(negedge clk) ring_out_ready = 2'b11;
        repeat (12) @(posedge clk);
        exp_q = '{17'h10111, 17'h10112, 17'h10113, 17'h10114, 17'h10115, 17'h10116};
        check_out("bp", 0, b0);

        // Single-flit packets through a full channel-1 FIFO while draining
        @(negedge clk) local_out_ready = 1'b0;
        b1 = out1.size(); bl = outl.size();
        for (int i = 0; i < 4; i++) src1.push_back(17'h10005);
        src1.push_back(17'h18005);
        src1.push_back(17'h10005);
        repeat (10) @(posedge clk);
        #2;
        check("full_held", 32'(outl.size() - bl), 32'h0);
        check("full_ready_low", 32'(ring_in_ready[1]), 32'h0);
        @(negedge clk) local_out_ready = 1'b1;
        repeat (15) @(posedge clk);
        exp_q = '{17'h10005, 17'h10005, 17'h10005, 17'h10005, 17'h10005};
        check_out("full_ej", 2, bl);
        exp_q = '{17'h18005};
        check_out("full_fwd", 1, b1);

        // Reset in the middle of a forwarded packet
        b1 = out1.size();
        @(negedge clk);
        src1.push_back(17'h00007); src1.push_back(17'h0A1A1);
        src1.push_back(17'h0A2A2); src1.push_back(17'h1A3A3);
        for (int k = 0; k < 20 && out1.size() < b1 + 2; k++) @(posedge clk);
        check("mid_fwd_count", 32'(out1.size() - b1), 32'd2);
        #3 rst_n = 1'b0;
        src1.delete();
        #1;
        check("mid_out_valid", 32'({ring_out[35], ring_out[17]}), 32'h0);
        check("mid_local_out", 32'(local_out[17]), 32'h0);
        check("mid_in_ready", 32'({local_in_ready, ring_in_ready}), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        b1 = out1.size(); bl = outl.size();
        @(negedge clk);
        src1.push_back(17'h00007); src1.push_back(17'h1C1C1);
        repeat (8) @(posedge clk);
        exp_q = '{17'h00007, 17'h1C1C1};
        check_out("post_rst", 1, b1);
        check("post_rst_no_eject", 32'(outl.size() - bl), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
